// File: rtl/videogen_multi_if.sv
`default_nettype none
// ============================================================================
// videogen_multi_if : RGB/sync/DE video bundle between generator and output path
// Rev 1.0
// ============================================================================
interface videogen_multi_if #(
    parameter int COLOR_BITS = 8
);
    logic [COLOR_BITS-1:0] R_out;
    logic [COLOR_BITS-1:0] G_out;
    logic [COLOR_BITS-1:0] B_out;
    logic                  HSYNC_out;
    logic                  VSYNC_out;
    logic                  PCLK_out;
    logic                  ENABLE_out;
    logic                  frame_start;
    logic                  mode_active;

    modport master (
        output R_out, G_out, B_out, HSYNC_out, VSYNC_out, PCLK_out,
        output ENABLE_out, frame_start, mode_active
    );

    modport slave (
        input R_out, G_out, B_out, HSYNC_out, VSYNC_out, PCLK_out,
        input ENABLE_out, frame_start, mode_active
    );
endinterface
`default_nettype wire

// File: rtl/videogen_multi.sv
`default_nettype none
// ============================================================================
// videogen_multi : 480p/576p test-pattern generator; colour bars on pattern 3 via VIDEOGEN_COLORBARS_EN
// Rev 1.0
// ============================================================================
module videogen_multi #(
    parameter int COLOR_BITS = 8,
    parameter int H_OVERSCAN = 40,
    parameter int V_OVERSCAN = 16,
    parameter int CHECK_LOG2 = 3
) (
    input  wire logic                    clk27,
    input  wire logic                    reset_n,
    input  wire logic                    mode_sel,
    input  wire logic [1:0]              pattern_sel,
    input  wire logic [3*COLOR_BITS-1:0] fill_rgb,
    videogen_multi_if.master             vid
);
    localparam logic [9:0] H_ACTIVE     = 10'd720;
    localparam logic [9:0] H_OVS        = 10'(H_OVERSCAN);
    localparam logic [9:0] V_OVS        = 10'(V_OVERSCAN);
    localparam logic [9:0] INNER_X0     = 10'(H_OVERSCAN + (720 - 2*H_OVERSCAN - 512) / 2);
    localparam logic [9:0] INNER_Y0_480 = 10'(V_OVERSCAN + (480 - 2*V_OVERSCAN - 256) / 2);
    localparam logic [9:0] INNER_Y0_576 = 10'(V_OVERSCAN + (576 - 2*V_OVERSCAN - 256) / 2);
    localparam logic [7:0] LVL_MAX      = 8'hFF;
    localparam logic [7:0] LVL_BORDER   = 8'h50;

    logic [9:0]              h_q, h_d, v_q, v_d;
    logic                    mode_q;
    logic [1:0]              pat_q;
    logic [3*COLOR_BITS-1:0] fill_q;
    logic [COLOR_BITS-1:0]   r_q, r_d, g_q, g_d, b_q, b_d;
    logic                    hs_q, vs_q, de_q, fs_q, ma_q;

    logic [9:0] h_last, v_last, h_sync, v_sync, x_start, y_start, v_active, inner_y0;
    logic [9:0] ax, ay;
    logic       frame_end, active, in_window, in_inner;
    logic [7:0] lvl_p0, lvl_chk;

    function automatic logic [COLOR_BITS-1:0] to_cb(input logic [7:0] v8);
        logic [COLOR_BITS-1:0] t;
        t = COLOR_BITS'(v8);
        return t << (COLOR_BITS - 8);
    endfunction

    always_comb begin
        if (mode_q) begin
            h_last   = 10'd863;
            v_last   = 10'd624;
            h_sync   = 10'd64;
            v_sync   = 10'd5;
            x_start  = 10'd132;
            y_start  = 10'd44;
            v_active = 10'd576;
            inner_y0 = INNER_Y0_576;
        end else begin
            h_last   = 10'd857;
            v_last   = 10'd524;
            h_sync   = 10'd62;
            v_sync   = 10'd6;
            x_start  = 10'd122;
            y_start  = 10'd36;
            v_active = 10'd480;
            inner_y0 = INNER_Y0_480;
        end
    end

    assign frame_end = (h_q == h_last) && (v_q == v_last);

    always_comb begin
        h_d = h_q + 10'd1;
        v_d = v_q;
        if (h_q == h_last) begin
            h_d = '0;
            v_d = (v_q == v_last) ? '0 : v_q + 10'd1;
        end
    end

    // Active-relative coordinates; only meaningful while inside the active area.
    assign ax        = h_q - x_start;
    assign ay        = v_q - y_start;
    assign active    = (h_q >= x_start) && (h_q < x_start + H_ACTIVE) &&
                       (v_q >= y_start) && (v_q < y_start + v_active);
    assign in_window = (ax >= H_OVS) && (ax < H_ACTIVE - H_OVS) &&
                       (ay >= V_OVS) && (ay < v_active - V_OVS);
    assign in_inner  = (ax >= INNER_X0) && (ax < INNER_X0 + 10'd512) &&
                       (ay >= inner_y0) && (ay < inner_y0 + 10'd256);
    assign lvl_chk   = (ax[CHECK_LOG2] ^ ay[CHECK_LOG2]) ? LVL_MAX : 8'h00;

    always_comb begin
        if (!in_window) begin
            lvl_p0 = (h_q[0] ^ v_q[0]) ? LVL_MAX : 8'h00;
        end else if (in_inner) begin
            lvl_p0 = 8'((ax - INNER_X0) >> 1);
        end else begin
            lvl_p0 = LVL_BORDER;
        end
    end

`ifdef VIDEOGEN_COLORBARS_EN
    localparam logic [7:0] LVL_BAR = 8'hBF;
    logic [2:0] bar_idx;

    // Bar order white..black maps to index bits as ~R=bit1, ~G=bit2, ~B=bit0.
    always_comb begin
        bar_idx = '0;
        for (int k = 1; k < 8; k++) begin
            if (ax >= 10'(90 * k)) bar_idx = 3'(k);
        end
    end
`endif

    always_comb begin
        r_d = '0;
        g_d = '0;
        b_d = '0;
        if (active) begin
            case (pat_q)
                2'd1: begin
                    r_d = fill_q[3*COLOR_BITS-1 -: COLOR_BITS];
                    g_d = fill_q[2*COLOR_BITS-1 -: COLOR_BITS];
                    b_d = fill_q[COLOR_BITS-1:0];
                end
                2'd2: begin
                    r_d = to_cb(lvl_chk);
                    g_d = to_cb(lvl_chk);
                    b_d = to_cb(lvl_chk);
                end
`ifdef VIDEOGEN_COLORBARS_EN
                2'd3: begin
                    r_d = bar_idx[1] ? '0 : to_cb(LVL_BAR);
                    g_d = bar_idx[2] ? '0 : to_cb(LVL_BAR);
                    b_d = bar_idx[0] ? '0 : to_cb(LVL_BAR);
                end
`endif
                default: begin
                    r_d = to_cb(lvl_p0);
                    g_d = to_cb(lvl_p0);
                    b_d = to_cb(lvl_p0);
                end
            endcase
        end
    end

    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            h_q    <= '0;
            v_q    <= '0;
            mode_q <= 1'b0;
            pat_q  <= '0;
            fill_q <= '0;
            r_q    <= '0;
            g_q    <= '0;
            b_q    <= '0;
            hs_q   <= 1'b0;
            vs_q   <= 1'b0;
            de_q   <= 1'b0;
            fs_q   <= 1'b0;
            ma_q   <= 1'b0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
            if (frame_end) begin
                mode_q <= mode_sel;
                pat_q  <= pattern_sel;
                fill_q <= fill_rgb;
            end
            r_q  <= r_d;
            g_q  <= g_d;
            b_q  <= b_d;
            hs_q <= (h_q >= h_sync);
            vs_q <= (v_q >= v_sync);
            de_q <= active;
            fs_q <= (h_q == '0) && (v_q == '0);
            ma_q <= mode_q;
        end
    end

    assign vid.R_out       = r_q;
    assign vid.G_out       = g_q;
    assign vid.B_out       = b_q;
    assign vid.HSYNC_out   = hs_q;
    assign vid.VSYNC_out   = vs_q;
    assign vid.ENABLE_out  = de_q;
    assign vid.frame_start = fs_q;
    assign vid.mode_active = ma_q;
    assign vid.PCLK_out    = clk27;
endmodule
`default_nettype wire

// File: tb/tb_videogen_multi.sv
`default_nettype none
// ============================================================================
// tb_videogen_multi : frame-level reference model, spot table and reset sequences
// Rev 1.0
// ============================================================================
module tb_videogen_multi;
    localparam int CB  = 8;
    localparam int HOV = 40;
    localparam int VOV = 16;

    typedef struct { logic [7:0] r, g, b; logic hs, vs, de; } px_t;
    typedef struct { int frame; int v; int h; logic [23:0] rgb; logic ma; } spot_t;
    typedef struct { logic mode; logic [1:0] pat; logic [23:0] fill; } plan_t;

    logic            clk27 = 1'b0;
    logic            reset_n = 1'b0;
    logic            mode_sel = 1'b0;
    logic [1:0]      pattern_sel = 2'd0;
    logic [3*CB-1:0] fill_rgb = '0;

    videogen_multi_if #(.COLOR_BITS(CB)) vif ();

    videogen_multi #(.COLOR_BITS(CB), .H_OVERSCAN(HOV), .V_OVERSCAN(VOV), .CHECK_LOG2(3)) dut (
        .clk27(clk27), .reset_n(reset_n), .mode_sel(mode_sel),
        .pattern_sel(pattern_sel), .fill_rgb(fill_rgb), .vid(vif)
    );

    always #5 clk27 = ~clk27;

    int errors = 0, checks = 0;
    int pos = 0, frame_no = 0, tcount = 0, si = 0;
    logic smode = 1'b0;
    logic [1:0] spat = 2'd0;
    logic [23:0] sfill = '0;
    int line_bad = 0;
    string line_msg = "";
    bit meas_armed = 0;
    logic meas_mode = 1'b0;
    int cnt_de, cnt_hs, cnt_vs, cnt_fs, last_fall = -1, last_int = 0;
    logic prev_hs = 1'b0;
    spot_t spots[$];
    plan_t plan[4];

    function automatic int h_total(logic m); return m ? 864 : 858; endfunction
    function automatic int v_total(logic m); return m ? 625 : 525; endfunction
    function automatic int hsl(logic m);     return m ? 64 : 62;   endfunction
    function automatic int vsl(logic m);     return m ? 5 : 6;     endfunction
    function automatic int xst(logic m);     return m ? 64 + 68 : 62 + 60; endfunction
    function automatic int yst(logic m);     return m ? 5 + 39 : 6 + 30;   endfunction
    function automatic int vact(logic m);    return m ? 576 : 480; endfunction

    function automatic logic [23:0] bar_rgb(int i);
        case (i)
            0: return 24'hBFBFBF;  1: return 24'hBFBF00;
            2: return 24'h00BFBF;  3: return 24'h00BF00;
            4: return 24'hBF00BF;  5: return 24'hBF0000;
            6: return 24'h0000BF;  default: return 24'h000000;
        endcase
    endfunction

    function automatic int p0_level(logic m, int h, int v);
        int ax, ay, ix0, iy0;
        ax  = h - xst(m);
        ay  = v - yst(m);
        ix0 = HOV + (720 - 2*HOV - 512) / 2;
        iy0 = VOV + (vact(m) - 2*VOV - 256) / 2;
        if (!(ax >= HOV && ax < 720 - HOV && ay >= VOV && ay < vact(m) - VOV))
            return ((h ^ v) & 1) != 0 ? 255 : 0;
        if (ax >= ix0 && ax < ix0 + 512 && ay >= iy0 && ay < iy0 + 256)
            return ((ax - ix0) / 2) % 256;
        return 'h50;
    endfunction

    function automatic px_t expect_px(logic m, logic [1:0] p, logic [23:0] f, int h, int v);
        px_t e;
        int ax, ay, lvl;
        ax   = h - xst(m);
        ay   = v - yst(m);
        e.hs = (h >= hsl(m));
        e.vs = (v >= vsl(m));
        e.de = (ax >= 0) && (ax < 720) && (ay >= 0) && (ay < vact(m));
        {e.r, e.g, e.b} = 24'h0;
        lvl = p0_level(m, h, v);
        if (e.de) begin
            case (p)
                2'd1: {e.r, e.g, e.b} = f;
                2'd2: begin
                    lvl = (((ax ^ ay) >> 3) & 1) != 0 ? 255 : 0;
                    {e.r, e.g, e.b} = {3{8'(lvl)}};
                end
`ifdef VIDEOGEN_COLORBARS_EN
                2'd3: {e.r, e.g, e.b} = bar_rgb(ax / 90);
`endif
                default: {e.r, e.g, e.b} = {3{8'(lvl)}};
            endcase
        end
        return e;
    endfunction

    function automatic logic [29:0] sample();
        return {vif.R_out, vif.G_out, vif.B_out, vif.HSYNC_out, vif.VSYNC_out,
                vif.ENABLE_out, vif.frame_start, vif.mode_active};
    endfunction

    task automatic check(input bit ok, input string name, input string detail);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    task automatic check_zero(input string name);
        logic [29:0] got;
        got = sample();
        check(got == 30'd0, name, $sformatf("outputs got %h need 0", got));
    endtask

    task automatic finalize();
        int x_de, x_hs, x_vs, x_ht;
        if (meas_mode) begin x_de = 414720; x_hs = 40000; x_vs = 4320; x_ht = 864; end
        else           begin x_de = 345600; x_hs = 32550; x_vs = 5148; x_ht = 858; end
        check(cnt_de == x_de, "frame_de", $sformatf("got %0d need %0d", cnt_de, x_de));
        check(cnt_hs == x_hs, "frame_hs_low", $sformatf("got %0d need %0d", cnt_hs, x_hs));
        check(cnt_vs == x_vs, "frame_vs_low", $sformatf("got %0d need %0d", cnt_vs, x_vs));
        check(cnt_fs == 1, "frame_start_count", $sformatf("got %0d need 1", cnt_fs));
        check(last_int == x_ht, "line_length", $sformatf("got %0d need %0d", last_int, x_ht));
    endtask

    task automatic model_reset();
        pos = 0; frame_no = 4; smode = 1'b0; spat = 2'd0; sfill = '0;
        line_bad = 0; meas_armed = 0; last_fall = -1; prev_hs = 1'b0;
    endtask

    task automatic tick();
        px_t e;
        logic [29:0] ex, got;
        int ht, hp, vp, fp;
        logic mp;
        ht = h_total(smode); hp = pos % ht; vp = pos / ht; fp = frame_no; mp = smode;
        e  = expect_px(smode, spat, sfill, hp, vp);
        ex = {e.r, e.g, e.b, e.hs, e.vs, e.de, (pos == 0), smode};
        @(posedge clk27);
        pos++;
        if (pos == ht * v_total(mp)) begin
            pos = 0; frame_no++; smode = mode_sel; spat = pattern_sel; sfill = fill_rgb;
        end
        @(negedge clk27);
        tcount++;
        got = sample();
        if (got !== ex) begin
            if (line_bad == 0)
                line_msg = $sformatf("frame %0d v=%0d h=%0d got %h need %h", fp, vp, hp, got, ex);
            line_bad++;
        end
        if (hp == 0 && vp == 0) begin
            if (meas_armed) finalize();
            meas_armed = 1; meas_mode = mp;
            cnt_de = 0; cnt_hs = 0; cnt_vs = 0; cnt_fs = 0;
        end
        cnt_de += int'(vif.ENABLE_out);
        cnt_hs += int'(!vif.HSYNC_out);
        cnt_vs += int'(!vif.VSYNC_out);
        cnt_fs += int'(vif.frame_start);
        if (prev_hs && !vif.HSYNC_out) begin
            if (last_fall >= 0) last_int = tcount - last_fall;
            last_fall = tcount;
        end
        prev_hs = vif.HSYNC_out;
        if (si < spots.size() && spots[si].frame == fp && spots[si].v == vp && spots[si].h == hp) begin
            check({vif.R_out, vif.G_out, vif.B_out, vif.mode_active} == {spots[si].rgb, spots[si].ma},
                  $sformatf("spot_f%0d_v%0d_h%0d", fp, vp, hp),
                  $sformatf("rgb/mode got %h/%b need %h/%b", {vif.R_out, vif.G_out, vif.B_out},
                            vif.mode_active, spots[si].rgb, spots[si].ma));
            si++;
        end
        if (hp == ht - 1) begin
            check(line_bad == 0, "line", line_msg);
            line_bad = 0;
        end
    endtask

    // Random mid-frame input churn, then the planned settings during the last lines.
    task automatic drive(input int f);
        int total;
        total = h_total(smode) * v_total(smode);
        if (f < 3 && pos >= total - 4 * h_total(smode)) begin
            mode_sel = plan[f+1].mode; pattern_sel = plan[f+1].pat; fill_rgb = plan[f+1].fill;
        end else if ($urandom_range(299) == 0) begin
            mode_sel = 1'($urandom); pattern_sel = 2'($urandom); fill_rgb = 24'($urandom);
        end
    endtask

    initial begin
        plan[0] = '{1'b0, 2'd0, 24'h000000};
        plan[1] = '{1'b0, 2'd1, 24'hFF0080};
        plan[2] = '{1'b1, 2'd2, 24'($urandom)};
        plan[3] = '{1'b0, 2'd3, 24'($urandom)};
        spots.push_back('{0, 148, 132, 24'h000000, 1'b0});
        spots.push_back('{0, 148, 133, 24'hFFFFFF, 1'b0});
        spots.push_back('{0, 148, 172, 24'h505050, 1'b0});
        spots.push_back('{0, 148, 226, 24'h000000, 1'b0});
        spots.push_back('{0, 148, 228, 24'h010101, 1'b0});
        spots.push_back('{0, 148, 737, 24'hFFFFFF, 1'b0});
        spots.push_back('{0, 148, 738, 24'h505050, 1'b0});
        spots.push_back('{1, 35, 500, 24'h000000, 1'b0});
        spots.push_back('{1, 36, 121, 24'h000000, 1'b0});
        spots.push_back('{1, 36, 122, 24'hFF0080, 1'b0});
        spots.push_back('{1, 515, 841, 24'hFF0080, 1'b0});
        spots.push_back('{1, 516, 500, 24'h000000, 1'b0});
        spots.push_back('{2, 44, 132, 24'h000000, 1'b1});
        spots.push_back('{2, 44, 139, 24'h000000, 1'b1});
        spots.push_back('{2, 44, 140, 24'hFFFFFF, 1'b1});
        spots.push_back('{2, 52, 132, 24'hFFFFFF, 1'b1});
        spots.push_back('{2, 52, 140, 24'h000000, 1'b1});
        spots.push_back('{2, 619, 851, 24'h000000, 1'b1});
`ifdef VIDEOGEN_COLORBARS_EN
        spots.push_back('{3, 36, 122, 24'hBFBFBF, 1'b0});
        spots.push_back('{3, 36, 123, 24'hBFBFBF, 1'b0});
        spots.push_back('{3, 36, 212, 24'hBFBF00, 1'b0});
        spots.push_back('{3, 36, 302, 24'h00BFBF, 1'b0});
        spots.push_back('{3, 36, 841, 24'h000000, 1'b0});
`else
        spots.push_back('{3, 36, 122, 24'h000000, 1'b0});
        spots.push_back('{3, 36, 123, 24'hFFFFFF, 1'b0});
        spots.push_back('{3, 36, 212, 24'h000000, 1'b0});
        spots.push_back('{3, 36, 302, 24'h000000, 1'b0});
        spots.push_back('{3, 36, 841, 24'hFFFFFF, 1'b0});
`endif

        repeat (3) @(negedge clk27);
        check_zero("reset_state");
        reset_n = 1'b1;
        model_reset();
        frame_no = 0;

        for (int f = 0; f < 3; f++) begin
            while (frame_no == f) begin
                drive(f);
                tick();
            end
        end
        for (int n = 0; n < 100000 && pos != 45 * 858 + 300; n++) begin
            drive(3);
            tick();
        end

        check(line_bad == 0, "line_before_reset", line_msg);
        reset_n = 1'b0;
        #1;
        check_zero("reset_async");
        repeat (2) @(negedge clk27);
        check_zero("reset_held");
        reset_n = 1'b1;
        model_reset();
        repeat (40 * 858) begin
            drive(4);
            tick();
        end

        check(si == spots.size(), "spots_reached", $sformatf("got %0d need %0d", si, spots.size()));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
